ccff_bitstream_loader: RTL and testbench
========================================

Name: ccff_bitstream_loader

Overview:
- Upstream feeder of the fabric configuration chain: the last stage before the bottom-row tiles' ccff_head.
- Accepts configuration bytes from the SoC-side host over a valid/ready stream and serialises them MSB-first onto ccff_head.
- Drives a shift-enable that the chain clock gate uses, so the chain advances only on enabled cycles.
- Prepends an 8-bit sentinel and checks it at the returning ccff_tail; this proves chain length and continuity before done is raised.

Parameters:
- CHAIN_LEN, 4096: number of configuration flops in the chain (>= 8).
- SENTINEL, 8'hA5: pattern shifted ahead of the bitstream and checked at ccff_tail.
- CNT_W, $clog2(CHAIN_LEN+9): width of the shift counter.

Ports:
- prog_clk  in  1  configuration clock.
- prog_reset  in  1  reset.
- start  in  1  single-cycle pulse; begins a load from IDLE, DONE or ERROR.
- s_data  in  8  configuration byte; bit 7 is shifted first.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader can take a byte this cycle.
- ccff_head  out  1  serial data into the chain.
- ccff_shift_en  out  1  chain advances on the prog_clk edge ending this cycle.
- ccff_tail  in  1  serial data returning from the chain end.
- busy  out  1  high in SENT, LOAD.
- done  out  1  level; load complete and sentinel matched.
- error  out  1  level; sentinel mismatch.
- shift_count  out  CNT_W  enabled shifts performed in the current load.

Behaviour:
- Clock and reset: one clock, prog_clk. prog_reset is asynchronous and active-low.
- Reset values: state=IDLE, s_ready=0, ccff_head=0, ccff_shift_en=0, busy=0, done=0, error=0, shift_count=0, shift register empty.
- Reset asserted mid-load aborts immediately. The chain contents are then undefined and the host must restart.
- States (encoding in package): IDLE, SENT, LOAD, DONE, ERROR.
- IDLE: all strobes low. On start go to SENT, with shift_count=0 and done/error cleared.
- SENT:
  - 8 consecutive cycles with ccff_shift_en=1 and ccff_head=SENTINEL[7-i]; no host handshake.
  - Then go to LOAD.
- LOAD:
  - s_ready=1 when the byte shift register is empty, or holds its last bit and that bit is shifting this cycle. This gives a zero-bubble back-to-back byte stream.
  - A byte is accepted on s_valid&&s_ready and is shifted MSB-first, one bit per enabled cycle.
  - ccff_shift_en=1 only while the shift register holds a bit. When the host starves, ccff_shift_en=0 and ccff_head holds its last value.
- Counting: shift_count increments on every cycle with ccff_shift_en=1, in SENT and LOAD. It saturates at CHAIN_LEN+8 and does not wrap.
- Sentinel check:
  - On each enabled shift with pre-increment shift_count=n, where CHAIN_LEN <= n <= CHAIN_LEN+7, compare ccff_tail with SENTINEL[7-(n-CHAIN_LEN)].
  - Any mismatch sets a sticky mismatch flag.
- Termination:
  - When shift_count reaches CHAIN_LEN+8, go to DONE (flag clear) or ERROR (flag set). done or error rises in the cycle after the final enabled shift.
  - Bits remaining in a partially consumed final byte are discarded. (CHAIN_LEN+8 is not necessarily a multiple of 8 after the sentinel.)
  - s_ready=0 from the cycle in which the final bit is shifted.
- Full-chain invariant: after CHAIN_LEN+8 shifts the chain holds exactly the first CHAIN_LEN bitstream bits.
- DONE/ERROR: status held. Bytes offered by the host are not accepted. start re-enters SENT.
- Simultaneous events:
  - start while busy is ignored.
  - start in the same cycle as the final shift is ignored.
  - s_valid outside LOAD is never acknowledged.
- Latency: the first bitstream bit appears on ccff_head in the cycle after the byte handshake.

Decomposition:
- Package ccff_loader_pkg holds:
  - state enum (IDLE, SENT, LOAD, DONE, ERROR);
  - default SENTINEL constant;
  - function computing CNT_W.
- One sub-module, ccff_byte_serializer, covers the 8-bit parallel-in/serial-out shift register with a bit counter, load/shift handshake and an empty flag. The top level owns the FSM, shift_count and the sentinel comparator.

Test Plan:
1. Ideal chain model (CHAIN_LEN=16 flop delay line gated by ccff_shift_en), s_valid held high, bytes 8'h12,8'h34,8'h56 -> 24 shifts total, model holds 16'h1234, sentinel matched, done=1 and error=0 one cycle after shift 24; third byte fully discarded; shift_count=24.
2. Same setup with s_valid toggling every other cycle -> ccff_shift_en low during gaps; model contents and done identical to scenario 1; shift_count never changes on gap cycles.
3. Chain model of length 15 (one flop short), CHAIN_LEN=16 -> error=1, done=0 after shift 24.
4. Chain model with ccff_tail stuck at 0 -> error=1 (SENTINEL 8'hA5 has ones); a subsequent start with a good model -> error cleared on start, done=1 at the end.
5. prog_reset pulled low at shift_count=10 -> all outputs return to reset values asynchronously (before the next prog_clk edge); after release, state IDLE, s_ready=0, no shifting until start.
6. start pulsed during LOAD and in the final-shift cycle -> no effect; shift_count monotonic, exactly one done rise.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg: shared state encoding, default sentinel and counter sizing for the chain loader.
package ccff_loader_pkg;
    typedef enum logic [2:0] {IDLE, SENT, LOAD, DONE, ERROR} state_t;
    localparam logic [7:0] DEFAULT_SENTINEL = 8'hA5;
    function automatic int cnt_width(input int chain_len);
        return $clog2(chain_len + 9);
    endfunction
endpackage

// File: rtl/ccff_byte_serializer.sv
// ccff_byte_serializer: 8-bit parallel-in, MSB-first serial-out register with a remaining-bit count.
module ccff_byte_serializer (
    input  logic       prog_clk,
    input  logic       prog_reset,
    input  logic       load_i,
    input  logic [7:0] data_i,
    input  logic       shift_i,
    input  logic       flush_i,
    output logic       bit_o,
    output logic       empty_o,
    output logic       last_o
);
    logic [7:0] sr_q, sr_d;
    logic [3:0] cnt_q, cnt_d;
    // A load coinciding with the last bit's shift replaces it, giving back-to-back bytes.
    always_comb begin
        sr_d  = flush_i ? sr_q : load_i ? data_i : shift_i ? {sr_q[6:0], 1'b0} : sr_q;
        cnt_d = flush_i ? 4'd0 : load_i ? 4'd8 : shift_i ? cnt_q - 4'd1 : cnt_q;
    end
    always_ff @(posedge prog_clk or negedge prog_reset) begin
        if (!prog_reset) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end
    assign bit_o   = sr_q[7];
    assign empty_o = cnt_q == 4'd0;
    assign last_o  = cnt_q == 4'd1;
endmodule

// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: shifts a sentinel then the host bitstream into the config chain and
// verifies the sentinel returning at the chain tail before reporting done.
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
#(
    parameter int         CHAIN_LEN = 4096,
    parameter logic [7:0] SENTINEL  = DEFAULT_SENTINEL,
    parameter int         CNT_W     = cnt_width(CHAIN_LEN)
) (
    input  logic             prog_clk,
    input  logic             prog_reset,
    input  logic             start,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             ccff_head,
    output logic             ccff_shift_en,
    input  logic             ccff_tail,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] shift_count
);
    localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(CHAIN_LEN + 7);
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(CHAIN_LEN + 8);
    localparam logic [CNT_W-1:0] SEN7_C = CNT_W'(7);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mismatch_q, mismatch_d, head_q;
    logic             ser_bit, ser_empty, ser_last;
    logic             in_sent, in_load, accept, final_shift, starting, tail_bad;
    logic [2:0]       sent_idx, tail_idx;

    assign in_sent       = state_q == SENT;
    assign in_load       = state_q == LOAD;
    assign busy          = in_sent || in_load;
    assign done          = state_q == DONE;
    assign error         = state_q == ERROR;
    assign ccff_shift_en = in_sent || (in_load && !ser_empty);
    assign sent_idx      = 3'd7 - cnt_q[2:0];
    assign tail_idx      = 3'd7 - (cnt_q[2:0] - LEN_C[2:0]);
    // The head keeps its last driven level whenever the chain is not advancing.
    assign ccff_head     = !ccff_shift_en ? head_q : in_sent ? SENTINEL[sent_idx] : ser_bit;
    assign final_shift   = in_load && ccff_shift_en && cnt_q == LAST_C;
    assign s_ready       = in_load && (ser_empty || (ser_last && ccff_shift_en)) && !final_shift;
    assign accept        = s_valid && s_ready;
    assign starting      = start && !busy;
    assign tail_bad      = ccff_shift_en && cnt_q >= LEN_C && ccff_tail != SENTINEL[tail_idx];

    always_comb begin
        state_d    = state_q;
        cnt_d      = starting ? '0 : (ccff_shift_en && cnt_q != MAX_C) ? cnt_q + 1'b1 : cnt_q;
        mismatch_d = starting ? 1'b0 : mismatch_q || tail_bad;
        case (state_q)
            IDLE, DONE, ERROR: state_d = start ? SENT : state_q;
            SENT:              state_d = cnt_q == SEN7_C ? LOAD : SENT;
            LOAD:              state_d = !final_shift ? LOAD : mismatch_d ? ERROR : DONE;
            default:           state_d = IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or negedge prog_reset) begin
        if (!prog_reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mismatch_q <= 1'b0;
            head_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mismatch_q <= mismatch_d;
            head_q     <= ccff_head;
        end
    end

    assign shift_count = cnt_q;

    ccff_byte_serializer u_ser (
        .prog_clk  (prog_clk),
        .prog_reset(prog_reset),
        .load_i    (accept),
        .data_i    (s_data),
        .shift_i   (in_load && ccff_shift_en),
        .flush_i   (final_shift),
        .bit_o     (ser_bit),
        .empty_o   (ser_empty),
        .last_o    (ser_last)
    );
endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// tb_ccff_bitstream_loader: drives loads into a modelled 16-flop chain and scoreboards the serial stream.
module tb_ccff_bitstream_loader;
    localparam int CL = 16;
    localparam int CW = $clog2(CL + 9);

    typedef struct {
        int          mode;
        bit          gaps;
        bit          poke;
        bit          exp_done;
        bit          exp_err;
        logic [15:0] exp_chain;
        bit          chk_chain;
    } vec_t;

    logic          prog_clk = 0, prog_reset = 0, start = 0, s_valid = 0;
    logic [7:0]    s_data = 0;
    logic          s_ready, ccff_head, ccff_shift_en, ccff_tail, busy, done, error;
    logic [CW-1:0] shift_count;
    logic [15:0]   chain = 0;
    logic [7:0]    bytes [3] = '{8'h12, 8'h34, 8'h56};
    logic [7:0]    sentinel = 8'hA5;
    int            mode = 0, vectors = 0, miscompares = 0, done_rises = 0;
    logic          exp_q [$];
    logic          p_busy = 0, p_en = 0, p_head = 0, p_done = 0, p_final = 0;
    logic [CW-1:0] p_cnt = 0;
    vec_t          vecs [6];

    ccff_bitstream_loader #(.CHAIN_LEN(CL), .SENTINEL(8'hA5)) dut (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start), .s_data(s_data),
        .s_valid(s_valid), .s_ready(s_ready), .ccff_head(ccff_head),
        .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail), .busy(busy), .done(done),
        .error(error), .shift_count(shift_count)
    );

    always #5 prog_clk = ~prog_clk;

    // mode 0: ideal 16-flop chain, 1: one flop short, 2: tail stuck at 0
    assign ccff_tail = mode == 2 ? 1'b0 : mode == 1 ? chain[14] : chain[15];
    always @(posedge prog_clk) if (ccff_shift_en) chain <= {chain[14:0], ccff_head};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge prog_clk) begin
        if (ccff_shift_en) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL head_unexpected: shift with no expected bit at %0t", $time);
            end else chk("head_bit", ccff_head, exp_q.pop_front());
        end
        if (s_valid && s_ready) for (int i = 7; i >= 0; i--) exp_q.push_back(s_data[i]);
        if (start && !busy && prog_reset) begin
            exp_q.delete();
            for (int i = 7; i >= 0; i--) exp_q.push_back(sentinel[i]);
        end
        if (p_busy && busy) begin
            chk("count_step", shift_count, p_cnt + p_en);
            if (!ccff_shift_en) chk("head_hold", ccff_head, p_head);
        end
        if (p_final) chk("status_after_final", done | error, 1);
        else if (busy) chk("status_while_busy", {done, error}, 0);
        if (!busy) chk("ready_outside_load", s_ready, 0);
        if (done && !p_done) done_rises++;
        p_final = busy && ccff_shift_en && shift_count == CW'(CL + 7);
        p_busy = busy; p_en = ccff_shift_en; p_head = ccff_head; p_done = done; p_cnt = shift_count;
    end

    task automatic pulse_start();
        @(posedge prog_clk); #1 start = 1; s_valid = 0;
        @(posedge prog_clk); #1 start = 0;
        @(negedge prog_clk);
        chk("start_status", {busy, done, error}, 3'b100);
        chk("start_count", shift_count, 0);
        @(posedge prog_clk); #1;
    endtask

    task automatic run(input vec_t v);
        int idx = 0, cyc = 0;
        bit hs, fin = 0;
        mode = v.mode;
        done_rises = 0;
        pulse_start();
        while (!fin && cyc < 200) begin
            s_valid = v.gaps ? cyc[0] : 1'b1;
            s_data = bytes[idx > 2 ? 2 : idx];
            start = v.poke && (idx == 1 || shift_count == CW'(CL + 7));
            @(negedge prog_clk);
            hs = s_valid && s_ready;
            fin = done || error;
            @(posedge prog_clk); #1;
            if (hs) idx++;
            cyc++;
        end
        if (!fin) chk("load_timeout", cyc, 0);
        s_valid = 0; start = 0;
        chk("done", done, v.exp_done);
        chk("error", error, v.exp_err);
        chk("final_count", shift_count, CL + 8);
        chk("bytes_taken", idx, 2);
        if (v.chk_chain) chk("chain", chain, v.exp_chain);
        repeat (3) @(negedge prog_clk);
        chk("done_rises", done_rises, v.exp_done);
        chk("status_held", {done, error}, {v.exp_done, v.exp_err});
    endtask

    initial begin
        vecs[0] = '{0, 0, 0, 1, 0, 16'h1234, 1};
        vecs[1] = '{0, 1, 0, 1, 0, 16'h1234, 1};
        vecs[2] = '{1, 0, 0, 0, 1, 16'h0000, 0};
        vecs[3] = '{2, 0, 0, 0, 1, 16'h0000, 0};
        vecs[4] = '{0, 0, 0, 1, 0, 16'h1234, 1};
        vecs[5] = '{0, 0, 1, 1, 0, 16'h1234, 1};
        #12;
        chk("rst_outputs", {s_ready, ccff_head, ccff_shift_en, busy, done, error}, 0);
        chk("rst_count", shift_count, 0);
        @(negedge prog_clk) prog_reset = 1;
        repeat (2) @(negedge prog_clk);
        chk("idle_outputs", {s_ready, ccff_shift_en, busy, done, error}, 0);
        foreach (vecs[i]) run(vecs[i]);

        mode = 0;
        pulse_start();
        s_valid = 1;
        s_data = 8'h3C;
        for (int c = 0; c < 50 && shift_count != CW'(10); c++) @(negedge prog_clk);
        chk("reached_10", shift_count, 10);
        #2 prog_reset = 0;
        #1;
        chk("async_rst_outputs", {s_ready, ccff_head, ccff_shift_en, busy, done, error}, 0);
        chk("async_rst_count", shift_count, 0);
        @(negedge prog_clk) prog_reset = 1;
        repeat (4) begin
            @(negedge prog_clk);
            chk("post_rst_idle", {s_ready, ccff_shift_en, busy}, 0);
            chk("post_rst_count", shift_count, 0);
        end
        s_valid = 0;
        run(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
